// File: rtl/muldiv_sequencer.sv
// Iterative MIPS mult/multu/div/divu unit owning HI/LO.
// One shared 32-step shift/add (mul) or restoring-subtract (div) datapath, 35-cycle fixed latency.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_hilo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  typedef struct packed {
    logic             is_div;
    logic             is_uns;
    logic [WIDTH-1:0] rs;
  } req_t;

  state_t state, state_nx;
  req_t   req;

  // acc:q form the 2*WIDTH product (mul) or remainder:quotient (div); b is multiplicand/divisor
  logic [WIDTH-1:0] acc, q, b;
  logic [CW-1:0]    cnt;
  logic             neg_lo, neg_hi;

  logic               sgn;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign sgn      = ~req.is_uns;
  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b};
  assign prod     = {acc, q};
  assign prod_fix = neg_lo ? -prod : prod;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start && !flush) state_nx = PREP;
      PREP: begin
        busy     = 1'b1;
        state_nx = flush ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)          state_nx = IDLE;
        else if (cnt == '0) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = flush ? IDLE : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    stall_req = busy & (rd_hilo | start);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req    <= '0;
      acc    <= '0;
      q      <= '0;
      b      <= '0;
      cnt    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          req.is_div <= op[1];
          req.is_uns <= op[0];
          req.rs     <= rs_val;
          q          <= rs_val;
          b          <= rt_val;
        end
        PREP: begin
          acc    <= '0;
          cnt    <= CW'(STEPS - 1);
          neg_lo <= sgn & (q[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi <= sgn & req.is_div & q[WIDTH-1];
          q      <= (sgn && q[WIDTH-1]) ? -q : q;
          b      <= (sgn && b[WIDTH-1]) ? -b : b;
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (req.is_div) begin
            // borrow out of the subtract means the partial remainder stays (restore)
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_sh[WIDTH-1:0];
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: if (!flush) begin
          if (!req.is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b == '0) begin
            // divide by zero: all-ones quotient, dividend returned untouched in HI
            hi <= req.rs;
            lo <= '1;
          end else begin
            hi <= neg_hi ? -acc : acc;
            lo <= neg_lo ? -q : q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + randomized bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, rd_hilo, flush;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, done, stall_req;
  logic [31:0] hi, lo;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .STEPS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .rd_hilo(rd_hilo), .flush(flush),
    .busy(busy), .done(done), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  // {hi, lo} as MIPS defines them, straight from integer arithmetic
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d);
    longint      sa, sd, qq, rr;
    logic [63:0] p;
    p = '0;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sd = longint'($signed(d));
        p  = 64'(sa * sd);
      end
      2'b01: p = {32'b0, a} * {32'b0, d};
      default: begin
        if (d == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          sa = longint'($signed(a));
          sd = longint'($signed(d));
          qq = sa / sd;
          rr = sa % sd;
          p  = {rr[31:0], qq[31:0]};
        end else p = {a % d, a / d};
      end
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full operation with cycle-exact busy/done/stall checks; optional rd_hilo and a stray start at N+5
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                        input bit hilo, input bit inject);
    logic [63:0] r;
    r      = ref_hilo(o, a, d);
    op     = o;
    rs_val = a;
    rt_val = d;
    start  = 1'b1;
    tick();
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) tick();
      start   = 1'b0;
      rs_val  = $urandom;
      rt_val  = $urandom;
      op      = 2'($urandom_range(0, 3));
      chk1("busy_run", busy, 1'b1);
      chk1("done_run", done, 1'b0);
      rd_hilo = hilo;
      if (inject && k == 5) start = 1'b1;
      #1;
      chk1("stall_run", stall_req, hilo | (inject && k == 5));
    end
    tick();
    start   = 1'b0;
    rd_hilo = 1'b0;
    exp_hi  = r[63:32];
    exp_lo  = r[31:0];
    chk1("done_pulse", done, 1'b1);
    chk1("busy_done", busy, 1'b0);
    chk32("hi", hi, exp_hi);
    chk32("lo", lo, exp_lo);
    rd_hilo = 1'b1;
    start   = 1'b1;
    #1;
    chk1("stall_done", stall_req, 1'b0);
    tick();
    start   = 1'b0;
    rd_hilo = 1'b0;
    chk1("busy_after_done", busy, 1'b0);
    chk1("done_after_done", done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, d;

    reset = 1'b1; start = 1'b1; rd_hilo = 1'b0; flush = 1'b0;
    op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_hi", hi, 32'h0);
    chk32("rst_lo", lo, 32'h0);
    rd_hilo = 1'b1;
    #1;
    chk1("rst_stall_idle", stall_req, 1'b0);
    rd_hilo = 1'b0;
    tick();
    chk1("rst_no_start", busy, 1'b0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk32("t1_hi", hi, 32'hFFFF_FFFE);
    chk32("t1_lo", lo, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk32("t2_mul_hi", hi, 32'hFFFF_FFFF);
    chk32("t2_mul_lo", lo, 32'hFFFF_FFF1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk32("t2_div_hi", hi, 32'hFFFF_FFFF);
    chk32("t2_div_lo", lo, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    chk32("t3_dz_hi", hi, 32'h0000_0007);
    chk32("t3_dz_lo", lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk32("t3_ovf_hi", hi, 32'h0);
    chk32("t3_ovf_lo", lo, 32'h8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    chk32("sdz_hi", hi, 32'hFFFF_FFF9);
    chk32("sdz_lo", lo, 32'hFFFF_FFFF);

    // flush mid-RUN leaves HI/LO alone and frees the unit immediately
    run_op(2'b01, 32'd1, 32'd2, 1'b0, 1'b0);
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk1("flush_done", done, 1'b0);
    chk32("flush_hi", hi, 32'h0);
    chk32("flush_lo", lo, 32'h2);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);

    // flush beats a simultaneous start in IDLE
    flush = 1'b1; start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    chk1("flush_start_idle", busy, 1'b0);
    tick();
    chk1("flush_start_idle2", busy, 1'b0);

    // flush in FIX must suppress the HI/LO write
    op = 2'b00; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (33) tick();
    chk1("fix_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fix_flush_busy", busy, 1'b0);
    chk1("fix_flush_done", done, 1'b0);
    chk32("fix_flush_hi", hi, exp_hi);
    chk32("fix_flush_lo", lo, exp_lo);

    run_op(2'b00, 32'd1234, 32'hFFFF_FF00, 1'b1, 1'b1);
    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);

    // reset mid-operation clears everything
    op = 2'b01; rs_val = $urandom; rt_val = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk32("midrst_hi", hi, exp_hi);
    chk32("midrst_lo", lo, exp_lo);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 5))
        0: d = 32'd0;
        1: a = 32'h8000_0000;
        2: d = 32'hFFFF_FFFF;
        3: d = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(o, a, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
